rr_grant_scheduler: RTL and testbench

//  Round-robin scheduler that shares one resource among N_REQ requesters.

---
 rtl/rr_grant_scheduler.sv | 173 +++++++++++++++++
 tb/tb_rr_grant_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
//
// Round-robin scheduler that shares one resource among N_REQ requesters.
// One requester is granted at a time. The grant is held until the grantee
// releases it, drops its request, or runs out of hold time. A single dead
// GAP cycle then follows, and the next requester in rotation is picked.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        level requests, bit i = requester i
//   done       release strobe from the current grantee
//   lock       (only with GRANT_LOCK_EN) freezes the hold timer while granted
//   grant_en   grant valid (high only in GRANT)
//   grant_idx  index of the current grantee
//   grant      one-hot decode of grant_idx, gated by grant_en
//   busy       high in GRANT or GAP
//   timeout    one-cycle pulse after a forced (hold-limit) release
//
// Configuration macro: GRANT_LOCK_EN
//   defined   -> adds the lock input. While lock is high in GRANT, the hold
//                counter is frozen and cannot force a release.
//   undefined -> no lock port. The MAX_HOLD limit is always enforced.
//
// The one-hot decode tree is built for IDX_W == 6 (N_REQ == 64).
// ---------------------------------------------------------------------------
module rr_grant_scheduler #(
    parameter int N_REQ    = 64,
    parameter int IDX_W    = 6,
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
`ifdef GRANT_LOCK_EN
    input  logic             lock,
`endif
    output logic             grant_en,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] ptr, ptr_next;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       hold_cnt, hold_next;
    logic             timeout_next;

    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] cand;
    logic             sel_found;
    logic             lock_active;

    logic [3:0]       dec_a, dec_b, dec_c;
    logic [15:0]      dec_low;

`ifdef GRANT_LOCK_EN
    assign lock_active = lock;
`else
    assign lock_active = 1'b0;
`endif

    // Outputs that follow the state directly.
    // They drop at the same moment the async reset forces the state to IDLE.
    assign grant_en = (state == ST_GRANT);
    assign busy     = (state != ST_IDLE);

    // Round-robin pick: the first set request found searching upward from
    // ptr. The candidate index wraps naturally at IDX_W bits.
    always_comb begin
        sel_idx   = ptr;
        sel_found = 1'b0;
        cand      = ptr;
        for (int i = 0; i < N_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!sel_found && req[cand]) begin
                sel_idx   = cand;
                sel_found = 1'b1;
            end
        end
    end

    // Next-state logic.
    // Release priority in GRANT is: done, then a silent request drop, then
    // the hold limit. So a done that coincides with expiry never raises timeout.
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        idx_next     = grant_idx;
        hold_next    = hold_cnt;
        timeout_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sel_found) begin
                    idx_next   = sel_idx;
                    hold_next  = 8'd0;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (done || !req[grant_idx]) begin
                    state_next = ST_GAP;
                    ptr_next   = grant_idx + IDX_W'(1);
                end else if (!lock_active && hold_cnt == HOLD_LAST) begin
                    state_next   = ST_GAP;
                    ptr_next     = grant_idx + IDX_W'(1);
                    timeout_next = 1'b1;
                end else if (!lock_active) begin
                    hold_next = hold_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    // timeout is registered, so it appears in the GAP cycle, as grant_en falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= 8'd0;
            grant_idx <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            ptr       <= ptr_next;
            hold_cnt  <= hold_next;
            grant_idx <= idx_next;
            timeout   <= timeout_next;
        end
    end

    // One-hot grant from a two-level decode tree of the registered index.
    // Three 2->4 predecoders feed a 4x4 -> 16 stage, and that stage is
    // combined with the top predecoder to reach 64 lines.
    // Only registers feed this tree, so req has no path to grant.
    always_comb begin
        dec_a   = 4'b0001 << grant_idx[1:0];
        dec_b   = 4'b0001 << grant_idx[3:2];
        dec_c   = 4'b0001 << grant_idx[5:4];
        dec_low = '0;
        grant   = '0;
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 4; i++) begin
                dec_low[4*j + i] = dec_b[j] & dec_a[i];
            end
        end
        for (int k = 0; k < 4; k++) begin
            for (int m = 0; m < 16; m++) begin
                grant[16*k + m] = grant_en & dec_c[k] & dec_low[m];
            end
        end
    end

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_grant_scheduler
//
// Self-checking bench for rr_grant_scheduler.
// Each expected grantee index is queued when its request is driven. A monitor
// pops the queue whenever a new grant starts and compares grant_idx and the
// one-hot grant against it. Timing properties are checked inline:
//   - hold length
//   - GAP and turnaround
//   - timeout pulse
//   - lock behaviour (GRANT_LOCK_EN)
// ---------------------------------------------------------------------------
module tb_rr_grant_scheduler;

    logic        clk;
    logic        rst_n;
    logic [63:0] req;
    logic        done;
`ifdef GRANT_LOCK_EN
    logic        lock;
`endif
    logic        grant_en;
    logic [5:0]  grant_idx;
    logic [63:0] grant;
    logic        busy;
    logic        timeout;

    int          check_count = 0;
    int          pass_count  = 0;
    int          timeout_seen = 0;
    logic        prev_en = 1'b0;
    logic [5:0]  exp_q[$];

    rr_grant_scheduler #(
        .N_REQ(64),
        .IDX_W(6),
        .MAX_HOLD(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
`ifdef GRANT_LOCK_EN
        .lock      (lock),
`endif
        .grant_en  (grant_en),
        .grant_idx (grant_idx),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive inputs just after a falling edge. Return 1 time unit after the
    // next falling edge, so the monitor has already run for that edge.
    task automatic applyStimulus(input logic [63:0] r, input logic d);
        req  = r;
        done = d;
        @(negedge clk);
        #1;
    endtask

    task automatic waitGrant(input logic [63:0] r, output int n);
        n = 0;
        while (!grant_en && n < 10) begin
            applyStimulus(r, 1'b0);
            n++;
        end
        checkOutput("grant_wait", 64'(grant_en), 64'd1);
    endtask

    // Scoreboard monitor: a rising grant_en marks a new grant.
    always @(negedge clk) begin
        logic [5:0] exp_idx;
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (timeout) timeout_seen++;
            if (grant_en && !prev_en) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_unexpected_grant", 64'(grant_idx), 64'hFFFF);
                end else begin
                    exp_idx = exp_q.pop_front();
                    checkOutput("sb_grant_idx", 64'(grant_idx), 64'(exp_idx));
                    checkOutput("sb_grant_onehot", grant, 64'h1 << exp_idx);
                end
            end
            prev_en = grant_en;
        end
    end

    initial begin
        int n;
        int cnt;
        int ts;
        logic [63:0] r2;
        logic [63:0] r5;

        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
`ifdef GRANT_LOCK_EN
        lock  = 1'b0;
`endif

        // Reset state
        #3;
        checkOutput("rst_grant_en", 64'(grant_en), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_timeout", 64'(timeout), 64'd0);
        checkOutput("rst_grant", grant, 64'd0);
        checkOutput("rst_grant_idx", 64'(grant_idx), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(64'd0, 1'b0);
        checkOutput("idle_busy", 64'(busy), 64'd0);

        // Reset mid-GRANT must clear outputs immediately
        exp_q.push_back(6'd0);
        applyStimulus(64'h1, 1'b0);
        checkOutput("lat1_grant_en", 64'(grant_en), 64'd1);
        checkOutput("grant_busy", 64'(busy), 64'd1);
        applyStimulus(64'h1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_grant", grant, 64'd0);
        checkOutput("async_rst_grant_en", 64'(grant_en), 64'd0);
        checkOutput("async_rst_busy", 64'(busy), 64'd0);
        applyStimulus(64'd0, 1'b0);
        rst_n = 1'b1;
        exp_q.push_back(6'd0);
        applyStimulus(64'h1, 1'b0);
        checkOutput("post_rst_grant_en", 64'(grant_en), 64'd1);
        applyStimulus(64'h1, 1'b1);
        applyStimulus(64'd0, 1'b0);

        // Rotation 0,4,63,0 with wrap
        rst_n = 1'b0;
        applyStimulus(64'd0, 1'b0);
        rst_n = 1'b1;
        r2 = 64'h8000_0000_0000_0011;
        exp_q.push_back(6'd0);
        exp_q.push_back(6'd4);
        exp_q.push_back(6'd63);
        exp_q.push_back(6'd0);
        for (int g = 0; g < 4; g++) begin
            waitGrant(r2, n);
            if (g > 0) checkOutput("rot_turnaround", 64'(n), 64'd2);
            applyStimulus(r2, 1'b0);
            applyStimulus(r2, 1'b1);
            checkOutput("rot_gap_en", 64'(grant_en), 64'd0);
            checkOutput("rot_gap_busy", 64'(busy), 64'd1);
            checkOutput("rot_gap_timeout", 64'(timeout), 64'd0);
        end
        applyStimulus(64'd0, 1'b0);
        checkOutput("rot_idle_busy", 64'(busy), 64'd0);

        // Timeout after 16 grant cycles, then regrant
        ts = timeout_seen;
        exp_q.push_back(6'd2);
        exp_q.push_back(6'd2);
        waitGrant(64'h4, n);
        cnt = 1;
        while (grant_en && cnt < 40) begin
            applyStimulus(64'h4, 1'b0);
            if (grant_en) cnt++;
        end
        checkOutput("to_hold_len", 64'(cnt), 64'd16);
        checkOutput("to_pulse", 64'(timeout), 64'd1);
        checkOutput("to_gap_busy", 64'(busy), 64'd1);
        applyStimulus(64'h4, 1'b0);
        checkOutput("to_pulse_width", 64'(timeout), 64'd0);
        waitGrant(64'h4, n);
        checkOutput("to_pulse_count", 64'(timeout_seen), 64'(ts + 1));
        applyStimulus(64'h4, 1'b1);
        checkOutput("to_done_no_pulse", 64'(timeout), 64'd0);
        applyStimulus(64'd0, 1'b0);

        // Tie: done on the hold_cnt==15 cycle wins over timeout
        ts = timeout_seen;
        exp_q.push_back(6'd2);
        waitGrant(64'h4, n);
        repeat (15) applyStimulus(64'h4, 1'b0);
        checkOutput("tie_still_granted", 64'(grant_en), 64'd1);
        applyStimulus(64'h4, 1'b1);
        checkOutput("tie_released", 64'(grant_en), 64'd0);
        checkOutput("tie_timeout", 64'(timeout), 64'd0);
        applyStimulus(64'd0, 1'b0);
        checkOutput("tie_timeout_count", 64'(timeout_seen), 64'(ts));

        // Silent request drop on the 3rd grant cycle
        ts = timeout_seen;
        r5 = 64'h0000_0000_0000_0220;
        exp_q.push_back(6'd5);
        exp_q.push_back(6'd9);
        waitGrant(r5, n);
        applyStimulus(r5, 1'b0);
        applyStimulus(r5, 1'b0);
        applyStimulus(64'h200, 1'b0);
        checkOutput("drop_gap_en", 64'(grant_en), 64'd0);
        checkOutput("drop_gap_busy", 64'(busy), 64'd1);
        checkOutput("drop_timeout", 64'(timeout), 64'd0);
        waitGrant(64'h200, n);
        checkOutput("drop_turnaround", 64'(n), 64'd2);
        applyStimulus(64'h200, 1'b1);
        applyStimulus(64'd0, 1'b0);
        checkOutput("drop_timeout_count", 64'(timeout_seen), 64'(ts));

        // done outside GRANT is ignored
        applyStimulus(64'd0, 1'b1);
        checkOutput("done_idle_busy", 64'(busy), 64'd0);
        applyStimulus(64'd0, 1'b0);

        // Lock: hold through 40 cycles, or time out at 16 without the feature
        ts = timeout_seen;
        exp_q.push_back(6'd2);
`ifdef GRANT_LOCK_EN
        lock = 1'b1;
        waitGrant(64'h4, n);
        repeat (39) applyStimulus(64'h4, 1'b0);
        checkOutput("lock_held_40", 64'(grant_en), 64'd1);
        applyStimulus(64'h4, 1'b1);
        checkOutput("lock_done_release", 64'(grant_en), 64'd0);
        checkOutput("lock_timeout", 64'(timeout), 64'd0);
        checkOutput("lock_timeout_count", 64'(timeout_seen), 64'(ts));
        lock = 1'b0;
`else
        waitGrant(64'h4, n);
        cnt = 1;
        while (grant_en && cnt < 40) begin
            applyStimulus(64'h4, 1'b0);
            if (grant_en) cnt++;
        end
        checkOutput("nolock_hold_len", 64'(cnt), 64'd16);
        checkOutput("nolock_timeout", 64'(timeout), 64'd1);
`endif
        applyStimulus(64'd0, 1'b0);
        applyStimulus(64'd0, 1'b0);

        checkOutput("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
